id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of PC/immediate/operand fields.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk in 1 (all state on rising edge); rst_n in 1 (asynchronous, active-low).
REQ-003 SHALL have id_valid in 1: the IF/ID register holds a real instruction.
REQ-004 SHALL have id_ctrl in 14: decoder outputs {ALUSrc, MemtoReg[1:0], RegWrite, MemRead, MemWrite, Branch, jalr, lui, jal, ALUOp[1:0], ReadFlag, WriteFlag}.
REQ-005 SHALL have id_pc, id_imm, id_rs1_data, id_rs2_data in DATA_W each: decode-stage operands.
REQ-006 SHALL have id_rs1, id_rs2, id_rd in 5 each, and id_funct in 4 ({funct7[5], funct3}).
REQ-007 SHALL have ex_redirect in 1: EX resolved a taken branch, jal or jalr this cycle.
REQ-008 SHALL have mem_hold in 1: the downstream stage cannot accept; freeze.
REQ-009 SHALL have ex_valid, ex_ctrl[13:0], ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_funct out: registered copies of the id_* fields.
REQ-010 SHALL have pc_write out 1 and ifid_write out 1: upstream enables; ifid_flush out 1: squash IF/ID.

Function
REQ-011 Load-use hazard SHALL be: ex_valid & ex_ctrl.MemRead & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-012 Priority per cycle SHALL be mem_hold > ex_redirect > load-use > normal advance.
REQ-013 mem_hold=1: all ex_* registers hold; pc_write=0; ifid_write=0; ifid_flush=0.
REQ-014 ex_redirect=1 (no hold): ex_valid<=0, ex_ctrl<=0 (bubble); ifid_flush=1; pc_write=1; ifid_write=1.
REQ-015 Load-use (no hold/redirect): bubble inserted (ex_valid<=0, ex_ctrl<=0); pc_write=0, ifid_write=0 for exactly that cycle; the next cycle advances the held instruction.
REQ-016 Normal: every ex_* field <= id_*; ex_valid<=id_valid; ex_ctrl <= id_valid ? id_ctrl : 0.
REQ-017 A bubble SHALL carry ex_ctrl==0, so RegWrite, MemWrite and Branch are never asserted for it; data fields of a bubble are don't-care but SHALL be deterministic (held).
REQ-018 pc_write, ifid_write and ifid_flush SHALL be combinational from current inputs and ex_* state; latency id->ex is exactly 1 cycle.
REQ-019 A load-use stall SHALL never exceed one consecutive cycle unless mem_hold intervenes.

Reset
REQ-020 On rst_n low: ex_valid=0, ex_ctrl=0, all ex_* data/index fields=0, counters=0, asynchronously.
REQ-021 Deassertion SHALL be synchronised externally; the first edge after release behaves as normal advance.
REQ-022 Reset mid-stall SHALL discard the bubble/hold; no state survives.

Configuration
REQ-023 Macro ID_EX_HAZARD_STATS_EN defined: adds outputs stall_cnt[31:0] (+1 per load-use cycle) and flush_cnt[31:0] (+1 per ex_redirect cycle without mem_hold), saturating at 0xFFFFFFFF.
REQ-024 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Package riscv_pkg SHALL hold opcode constants, the ctrl_t packed struct (14 bits, field order per REQ-004) and its CTRL_NOP=0 constant.
REQ-026 Sub-module hazard_detect (combinational, REQ-011/012 decisions) SHALL be instantiated once; registers live in id_ex_stage.

Verification
REQ-027 lw x5 in EX (MemRead=1, ex_rd=5), id_rs1=5 -> pc_write=0, ifid_write=0, next ex_ctrl=0; following cycle ex_rs1=5, ex_valid=1.
REQ-028 Same but ex_rd=0 -> no stall, pc_write=1, instruction advances.
REQ-029 ex_redirect=1 with simultaneous load-use -> ifid_flush=1, pc_write=1, bubble; stall_cnt unchanged, flush_cnt +1.
REQ-030 mem_hold=1 for 3 cycles with ex_redirect=1 -> ex_* unchanged all 3 cycles, ifid_flush=0.
REQ-031 rst_n low mid-stall (ex_ctrl=0x3FFF) -> immediately ex_valid=0, ex_ctrl=0, counters 0.
REQ-032 id_valid=0 with id_ctrl=0x3FFF -> ex_ctrl=0, ex_valid=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: opcodes, decoder control bundle, and the
// per-cycle action chosen for the ID/EX register.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jalr;
        logic       lui;
        logic       jal;
        logic [1:0] alu_op;
        logic       read_flag;
        logic       write_flag;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_REDIRECT,
        ACT_HOLD
    } stage_action_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard decision for the ID/EX boundary: picks one action per
// cycle (hold > redirect > load-use > advance) and the upstream enables.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [4:0]    ex_rd,
    input  logic          id_valid,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic          ex_redirect,
    input  logic          mem_hold,
    output stage_action_t action,
    output logic          pc_write,
    output logic          ifid_write,
    output logic          ifid_flush
);

    logic load_use;

    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        action     = ACT_ADVANCE;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (mem_hold) begin
            action     = ACT_HOLD;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_redirect) begin
            action     = ACT_REDIRECT;
            ifid_flush = 1'b1;
        end else if (load_use) begin
            action     = ACT_STALL;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, redirect bubble and freeze.
// Optional hazard counters: define ID_EX_HAZARD_STATS_EN.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [13:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [3:0]        id_funct,
    input  logic              ex_redirect,
    input  logic              mem_hold,
    output logic              ex_valid,
    output logic [13:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [3:0]        ex_funct,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush
`ifdef ID_EX_HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    ctrl_t         ex_ctrl_q;
    stage_action_t action;

    assign ex_ctrl = ex_ctrl_q;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_redirect (ex_redirect),
        .mem_hold    (mem_hold),
        .action      (action),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush)
    );

    // Bubbles clear only valid/ctrl; data fields hold so they stay deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl_q   <= CTRL_NOP;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else begin
            case (action)
                ACT_HOLD: begin
                end
                ACT_REDIRECT, ACT_STALL: begin
                    ex_valid  <= 1'b0;
                    ex_ctrl_q <= CTRL_NOP;
                end
                default: begin
                    ex_valid    <= id_valid;
                    ex_ctrl_q   <= id_valid ? ctrl_t'(id_ctrl) : CTRL_NOP;
                    ex_pc       <= id_pc;
                    ex_imm      <= id_imm;
                    ex_rs1_data <= id_rs1_data;
                    ex_rs2_data <= id_rs2_data;
                    ex_rs1      <= id_rs1;
                    ex_rs2      <= id_rs2;
                    ex_rd       <= id_rd;
                    ex_funct    <= id_funct;
                end
            endcase
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (action == ACT_STALL && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (action == ACT_REDIRECT && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
